// File: rtl/ram_writer.sv
// Sequential capture buffer: stores DATA_DEPTH streamed words at addresses 0..DEPTH-1 with an async read port.
// Optional sticky overflow flag is built only when RAM_WRITER_OVERFLOW_EN is defined.
module ram_writer #(
  parameter  int DATA_WIDTH = 16,
  parameter  int DATA_DEPTH = 16,
  localparam int ADDR_WIDTH = $clog2(DATA_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] wr_count,
  output logic                  overflow
);

  localparam logic [ADDR_WIDTH-1:0] LAST      = ADDR_WIDTH'(DATA_DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH + 1)'(DATA_DEPTH);

  typedef enum logic {IDLE, WRITE} state_t;

  state_t                state_q, state_d;
  logic                  accept;
  logic                  last_word;
  logic [DATA_WIDTH-1:0] mem [DATA_DEPTH];

  assign in_ready  = (state_q == WRITE);
  assign busy      = (state_q == WRITE);
  assign accept    = in_valid && in_ready;
  assign last_word = (wr_count == LAST);
  assign done      = accept && last_word;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = WRITE;
      WRITE:   if (done)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      wr_count <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && start)
        wr_count <= '0;
      else if (accept)
        wr_count <= last_word ? '0 : wr_count + 1'b1;
    end
  end

  // Storage is deliberately unreset so captured data survives a reset.
  always_ff @(posedge clk) begin
    if (accept) mem[wr_count] <= in_data;
  end

  // Guard keeps out-of-range addresses from indexing past the array on non-power-of-2 depths.
  always_comb begin
    rd_data = '0;
    if ({1'b0, rd_addr} < DEPTH_EXT) rd_data = mem[rd_addr];
  end

`ifdef RAM_WRITER_OVERFLOW_EN
  logic overflow_q;

  // Start clears ahead of a same-cycle set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      overflow_q <= 1'b0;
    else if (state_q == IDLE && start)
      overflow_q <= 1'b0;
    else if (state_q == IDLE && in_valid)
      overflow_q <= 1'b1;
  end

  assign overflow = overflow_q;
`else
  assign overflow = 1'b0;
`endif

endmodule

// File: doc/ram_writer.md
# ram_writer

Sequential capture buffer: the write-side counterpart of the ROM readout path. On `start` it accepts exactly `DATA_DEPTH` words from an upstream valid/ready stream, such as a feature extractor or a ROM readout, and writes them into an internal RAM at addresses 0..`DATA_DEPTH`-1. It pulses `done` on the final write. A combinational read port lets downstream logic, such as classifier layers, fetch stored words by address.

## Interface
Parameters:
- `DATA_WIDTH`, 16, width of each stored word
- `DATA_DEPTH`, 16, number of words captured per transfer; must be ≥2
- `ADDR_WIDTH`, localparam `$clog2(DATA_DEPTH)`, address width

Ports:
- Timing/reset decision: one clock; reset is asynchronous and active-low.
- `clk`  in  1  clock; all state updates on the rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `start`  in  1  begins a capture; sampled only in IDLE
- `in_valid`  in  1  upstream word valid
- `in_data`  in  `DATA_WIDTH`  upstream word
- `in_ready`  out  1  block accepts a word this cycle
- `rd_addr`  in  `ADDR_WIDTH`  read address
- `rd_data`  out  `DATA_WIDTH`  combinational read of `mem[rd_addr]`
- `busy`  out  1  capture in progress
- `done`  out  1  one-cycle pulse on the final accepted word
- `wr_count`  out  `ADDR_WIDTH`  address of the next word to be written
- `overflow`  out  1  sticky overflow flag; see Configuration

## Operation
- FSM states: IDLE and WRITE.
- IDLE -> WRITE when `start`=1. On that edge `wr_count` is cleared to 0.
- WRITE -> IDLE on the edge where the word at address `DATA_DEPTH`-1 is accepted.
- `start` is ignored while in WRITE.
- `in_ready` = (state==WRITE). It is a Moore output and does not depend on `in_valid`.
- Accept = `in_valid` && `in_ready`. On an accept edge:
  - `mem[wr_count]` <= `in_data`
  - `wr_count` increments, except on the last word, where it wraps to 0.
- No accept means no write and no count change. Stalls of any length are legal.
- `busy` = (state==WRITE).
- `done` = accept && (`wr_count`==`DATA_DEPTH`-1). It is combinational and high in the same cycle as the final accept.
- Read port: `rd_data` = `mem[rd_addr]`, asynchronous. It is valid in any state, including during capture.
- Read of the address being written in the same cycle: `rd_data` shows the old value until the edge and the new value after it.
- `rd_addr` ≥ `DATA_DEPTH` (non-power-of-2 depths): `rd_data` = 0.
- Memory is not reset. Contents persist across transfers and resets. A new transfer overwrites in order from 0.

## Timing
- Reset values: state=IDLE, `wr_count`=0, `in_ready`=0, `busy`=0, `done`=0, `overflow`=0.
- `start` at edge N:
  - `in_ready`=1 from cycle N+1.
  - The first word can be accepted at edge N+1.
- With `in_valid` held high, `DATA_DEPTH` words are accepted on consecutive edges N+1..N+`DATA_DEPTH`.
  - `done` is high during the cycle before edge N+`DATA_DEPTH`.
  - `in_ready` falls after that edge.
- `start` asserted in the same cycle as `done`: ignored, because the state is still WRITE. A new `start` is honoured in the following IDLE cycle.
- Reset asserted mid-capture:
  - Immediate return to IDLE with `wr_count`=0.
  - Words already written stay in memory. No `done` is produced.

## Configuration
- Macro: `RAM_WRITER_OVERFLOW_EN`.
- Defined:
  - `overflow` sets on any cycle with `in_valid`=1 and state==IDLE, i.e. the producer is pushing data that nobody accepts.
  - It clears only on reset or on `start` in IDLE. If set and clear occur in the same cycle, `start` clear wins.
- Undefined: `overflow` is tied to 0 and no flag register is built.

## Test plan
- Basic capture, DEPTH=16, WIDTH=16: `start` pulse, then 16 back-to-back words 0x1000..0x100F -> `done` high exactly during the cycle of the 16th accept. Then `busy`=0, `in_ready`=0, `wr_count`=0. `rd_addr`=0..15 returns 0x1000..0x100F.
- Stalled stream: toggle `in_valid` 1,0,0,1,... with data 0xA000+k -> only accepted words are stored, at consecutive addresses. `done` comes after the 16th accept regardless of gap count.
- Reset mid-capture: after 5 accepts of 0xBEE0..0xBEE4, drive `rst_n`=0 -> IDLE, `wr_count`=0, no `done`. `rd_addr`=0..4 still reads 0xBEE0..0xBEE4.
- Back-to-back transfers: hold `start` high through the first transfer's `done` cycle -> second capture starts one IDLE cycle after `done`. Second data set 0x2000.. fully overwrites addresses 0..15.
- Overflow (macro defined): in IDLE, drive `in_valid`=1 for one cycle -> `overflow`=1 and stays high. `start` clears it the next edge. With the macro undefined, `overflow` stays 0 throughout.
- Read/write same address: `rd_addr`=3 while word 0xCAFE is written at address 3 -> `rd_data` shows the old value before the edge and 0xCAFE after it.
